// File: rtl/irq_dispatch_c432_pkg.sv
// irq_dispatch_c432_pkg: shared bus encodings, event width and dispatcher state type
package irq_dispatch_c432_pkg;
  localparam logic [1:0] BUS_A = 2'd0;
  localparam logic [1:0] BUS_B = 2'd1;
  localparam logic [1:0] BUS_C = 2'd2;
  localparam int ENTRY_W = 6;
  typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_SERVICE} state_t;
endpackage

// File: rtl/irq_evt_fifo.sv
// irq_evt_fifo: synchronous event FIFO with exact occupancy count
// ports: clk, rst_n, push/din write side, pop/dout read side (dout shows head),
//        count 0..DEPTH, full, empty; a push while full only lands if a pop frees a slot
module irq_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/irq_dispatch_c432.sv
// irq_dispatch_c432: turns priority grants into queued host interrupt events with EOI tracking
// ports: clk, rst_n; pa_in/pb_in/pc_in/chan_in grant input; irq_valid/irq_ready/irq_bus/irq_chan
//        host handshake; eoi, in_service; fifo_count; sticky overflow/timeout_err/multi_err,
//        cleared by clr_status
module irq_dispatch_c432
  import irq_dispatch_c432_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pa_in,
  input  logic                   pb_in,
  input  logic                   pc_in,
  input  logic [3:0]             chan_in,
  output logic                   irq_valid,
  input  logic                   irq_ready,
  output logic [1:0]             irq_bus,
  output logic [3:0]             irq_chan,
  input  logic                   eoi,
  output logic                   in_service,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   timeout_err,
  output logic                   multi_err,
  input  logic                   clr_status
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t state, state_n;
  logic gv, push_req, pop, accept, done, tmo, full, empty, multi;
  logic [1:0] bus;
  logic [6:0] word, last_word;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0] cnt;
  assign gv = pa_in | pb_in | pc_in;
  assign bus = pa_in ? BUS_A : pb_in ? BUS_B : BUS_C;
  assign multi = (pa_in & pb_in) | (pa_in & pc_in) | (pb_in & pc_in);
  assign word = {gv, bus, chan_in};
  // a held grant pushes once; a gap or any change of bus/channel re-arms it
  assign push_req = gv && word != last_word;
  irq_evt_fifo #(.DEPTH(DEPTH), .W(ENTRY_W)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push_req), .pop(pop), .din(word[5:0]), .dout(head),
    .count(fifo_count), .full(full), .empty(empty)
  );
  always_comb begin
    state_n = state;
    pop = 1'b0;
    accept = 1'b0;
    done = 1'b0;
    tmo = 1'b0;
    case (state)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        state_n = S_PRESENT;
      end
      S_PRESENT: if (irq_ready) begin
        accept = 1'b1;
        state_n = S_SERVICE;
      end
      S_SERVICE: if (eoi) begin
        done = 1'b1;
        state_n = S_IDLE;
      end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
        tmo = 1'b1;
        done = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_word <= '0;
      irq_valid <= 1'b0;
      irq_bus <= '0;
      irq_chan <= '0;
      in_service <= 1'b0;
      cnt <= '0;
      overflow <= 1'b0;
      timeout_err <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      last_word <= word;
      if (pop) {irq_bus, irq_chan} <= head;
      irq_valid <= pop | (irq_valid & ~accept);
      in_service <= accept | (in_service & ~done);
      cnt <= accept ? '0 : state == S_SERVICE ? cnt + 1'b1 : cnt;
      overflow <= (push_req & full & ~pop) | (overflow & ~clr_status);
      timeout_err <= tmo | (timeout_err & ~clr_status);
      multi_err <= multi | (multi_err & ~clr_status);
    end
endmodule

// File: doc/irq_dispatch_c432.md
Name: irq_dispatch_c432

Overview:
- Downstream stage of the 27-channel (3 buses x 9 channels) interrupt priority top level.
- Consumes its registered grant outputs (PA/PB/PC plus 4-bit channel code).
- Turns each new grant into a queued interrupt event and presents events one at a time to the host through a valid/ready handshake.
- Tracks in-service state until end-of-interrupt (EOI), with timeout and overflow status.

Parameters:
- DEPTH, 4, event FIFO entries; power of two, >= 2.
- TIMEOUT, 255, max cycles in service before forced release; 0 disables the timeout.
- CNT_W, 8, width of the in-service cycle counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pa_in  in  1  grant on bus A
- pb_in  in  1  grant on bus B
- pc_in  in  1  grant on bus C
- chan_in  in  4  granted channel code
- irq_valid  out  1  event presented to host
- irq_ready  in  1  host accepts event
- irq_bus  out  2  0=A, 1=B, 2=C
- irq_chan  out  4  channel of presented event
- eoi  in  1  single-cycle end-of-interrupt pulse
- in_service  out  1  event accepted, EOI pending
- fifo_count  out  clog2(DEPTH)+1  queued entries
- overflow  out  1  sticky: a push was dropped
- timeout_err  out  1  sticky: in-service timed out
- multi_err  out  1  sticky: more than one of pa/pb/pc high
- clr_status  in  1  clears all sticky flags

Behaviour:
- Reset (asynchronous): all outputs 0, FIFO empty, last_word = none, state IDLE, counter 0.
- Grant decode:
  - grant_valid = pa|pb|pc.
  - bus is chosen A>B>C.
  - If more than one bit is high, multi_err is set and the priority pick is still used.
- Grant word = {grant_valid, bus, chan_in}; last_word is registered every cycle.
- Push condition: grant_valid && word != last_word.
  - A grant held stable pushes once.
  - A drop to none followed by return pushes again.
  - A change of bus or channel pushes.
- Full FIFO:
  - Push with no pop in the same cycle is dropped and sets overflow.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
- FIFO pointers wrap modulo DEPTH; fifo_count is exact in the range 0..DEPTH.
- FSM states: IDLE, PRESENT, SERVICE.
  - IDLE: if FIFO is non-empty, pop the head into the irq_bus/irq_chan registers, assert irq_valid, go to PRESENT. An entry pushed at edge k is presented after edge k+1 at the earliest.
  - PRESENT: irq_valid high; irq_bus/irq_chan held stable. On irq_valid&&irq_ready at an edge: drop irq_valid, set in_service, clear the counter, go to SERVICE.
  - SERVICE: counter increments each cycle.
    - On eoi: clear in_service, go to IDLE.
    - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without eoi: set timeout_err, clear in_service, go to IDLE.
    - eoi wins over timeout in the same cycle.
  - eoi outside SERVICE is ignored.
- No back-to-back presentation: at least one IDLE cycle after each EOI.
- clr_status clears all sticky flags. A flag-setting event in the same cycle as clr_status wins (flag stays set).
- Reset mid-operation discards the FIFO and the in-flight event.
- chan_in values 9..15 pass through unchecked.

Decomposition:
- Shared package: bus encodings BUS_A/BUS_B/BUS_C, event entry width (6 bits), FSM state constants.
- One sub-module: irq_evt_fifo (parameterised synchronous FIFO with count, full, empty).
- Grant decode, FSM and status logic stay in the top module.

Test Plan:
- Reset, then pa_in=1, chan_in=3 held 10 cycles:
  - exactly one push.
  - irq_valid rises 2 edges after the first sample, with irq_bus=0, irq_chan=3.
  - fifo_count returns to 0.
- Presented event with irq_ready low 5 cycles, then high: irq_bus/irq_chan stable throughout; in_service=1 on the next cycle; eoi pulse clears it; next entry is presented after one IDLE cycle.
- Grant changes each cycle across 6 distinct words (A3, B0, C8, A1, B5, C2) with irq_ready=0 and DEPTH=4:
  - 4 held in FIFO.
  - overflow=1 after the 6th grant.
  - clr_status clears it.
  - order preserved on drain.
- Full FIFO, with a pop and a new push in the same cycle: fifo_count stays 4, overflow stays 0.
- TIMEOUT=8, accept an event and never send eoi: in_service drops after 8 service cycles and timeout_err=1. A second run with eoi on the 8th cycle leaves timeout_err=0.
- pa_in=pb_in=1, chan_in=2: event bus=0 and multi_err=1. Also assert rst_n low while in_service: all outputs 0 immediately.
